// File: rtl/mmio_console.sv
// mmio_console
// Memory-mapped debug console. It sits on a memory_io port and exposes a
// 16-byte register window at BASE:
//   +0x0 SCRATCH  read/write 32-bit word, byte-enabled writes
//   +0x4 STATUS   read-only {halt, overflow, empty, full, count}
//   +0x8 TXDATA   write-only, pushes data[7:0] into the TX FIFO
//   +0xC HALT     write-only, sets the sticky halt flag
// Every valid request gets exactly one response one cycle later, so the
// port never stalls. Characters leave through a valid/ready stream.
//
// Ports
//   clk        single clock, rising edge
//   reset      synchronous, active-high
//   req        memory_io request (valid, addr, do_read, do_write, data, user_tag)
//   rsp        memory_io response (valid, addr, data, user_tag)
//   out_valid  a character is available at out_data
//   out_ready  sink accepts the character this cycle
//   out_data   character at the FIFO head (0 when the FIFO is empty)
//   halt       sticky program-halt flag, cleared only by reset

package memory_io_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [3:0]  do_read;
        logic [3:0]  do_write;
        logic [31:0] data;
        logic [7:0]  user_tag;
    } memory_io_req;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  user_tag;
    } memory_io_rsp;

endpackage

module mmio_console
    import memory_io_pkg::*;
#(
    parameter logic [31:0] BASE  = 32'h0002_FFF0,
    parameter int          DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  memory_io_req req,
    output memory_io_rsp rsp,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_data,
    output logic         halt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [1:0] OFF_SCRATCH = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_TXDATA  = 2'd2;
    localparam logic [1:0] OFF_HALT    = 2'd3;

    logic [7:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [31:0]   scratch;

    logic          in_window;
    logic [1:0]    offset;
    logic          is_write;
    logic          is_read;
    logic          full;
    logic          empty;
    logic          pop;
    logic          tx_write;
    logic          push;
    logic          drop;
    logic [31:0]   status;
    logic [31:0]   read_data;

    // Request decode. Writes win over reads when both enables are set.
    // Bits [1:0] of the address do not select anything: the window is
    // decoded on word granularity only.
    always_comb begin
        in_window = (req.addr[31:4] == BASE[31:4]);
        offset    = req.addr[3:2];
        is_write  = req.valid && (req.do_write != 4'b0000);
        is_read   = req.valid && (req.do_write == 4'b0000) && (req.do_read != 4'b0000);
    end

    // FIFO control. A push into a full FIFO is still taken when the head
    // leaves in the same cycle; the slot being written is the one being
    // vacated, so the new byte lands at the tail. Without a pop it is
    // dropped and remembered in the sticky overflow bit. A push into an
    // empty FIFO only shows up on out_data the following cycle.
    always_comb begin
        full     = (count == FULL_COUNT);
        empty    = (count == '0);
        pop      = !empty && out_ready;
        tx_write = is_write && in_window && (offset == OFF_TXDATA) && req.do_write[0];
        push     = tx_write && (!full || pop);
        drop     = tx_write && full && !pop;
    end

    // Read mux, built from the current (pre-update) state so a read never
    // sees a write or pop that happens in the same cycle.
    always_comb begin
        status           = '0;
        status[CW-1:0]   = count;
        status[8]        = full;
        status[9]        = empty;
        status[10]       = overflow;
        status[11]       = halt;
        read_data        = '0;
        if (in_window) begin
            case (offset)
                OFF_SCRATCH: read_data = scratch;
                OFF_STATUS:  read_data = status;
                default:     read_data = '0;
            endcase
        end
    end

    // FIFO storage has no reset; entries are only ever read while count
    // says they are live.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_mem[wr_ptr] <= req.data[7:0];
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // SCRATCH word and the sticky halt flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            scratch <= '0;
            halt    <= 1'b0;
        end else if (is_write && in_window) begin
            if (offset == OFF_SCRATCH) begin
                for (int i = 0; i < 4; i++) begin
                    if (req.do_write[i]) begin
                        scratch[8*i +: 8] <= req.data[8*i +: 8];
                    end
                end
            end
            if (offset == OFF_HALT) begin
                halt <= 1'b1;
            end
        end
    end

    // Response register: one response per valid request, one cycle later.
    // Writes and unmapped reads answer with zero data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp <= '0;
        end else begin
            rsp.valid    <= req.valid;
            rsp.addr     <= req.addr;
            rsp.user_tag <= req.user_tag;
            rsp.data     <= is_read ? read_data : 32'h0;
        end
    end

    assign out_valid = !empty;
    assign out_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

endmodule

// File: tb/tb_mmio_console.sv
// Self-checking bench for mmio_console. A queue-based reference model of the
// console (character queue, sticky flags, scratch word, expected response)
// is advanced once per clock by the cycle task; directed scenario tasks
// compare against hand-derived constants, the random task against the model.
module tb_mmio_console;
    import memory_io_pkg::*;

    localparam logic [31:0] BASE  = 32'h0002_FFF0;
    localparam int          DEPTH = 8;

    logic         clk = 1'b0;
    logic         reset;
    memory_io_req req;
    memory_io_rsp rsp;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic         halt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  mq[$];
    bit          m_ovf;
    bit          m_halt;
    logic [31:0] m_scr;
    bit          e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [7:0]  e_tag;

    mmio_console #(.BASE(BASE), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .rsp       (rsp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .halt      (halt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_status();
        return {20'h0, m_halt, m_ovf, (mq.size() == 0), (mq.size() == DEPTH), 8'(mq.size())};
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, then
    // wait until 1 time unit after the edge where outputs are sampled.
    task automatic cycle(input bit rst, input bit v, input logic [31:0] a,
                         input logic [3:0] rd, input logic [3:0] wr,
                         input logic [31:0] d, input logic [7:0] tag, input bit rdy);
        bit          isw;
        bit          isr;
        bit          inwin;
        logic [1:0]  off;
        reset         = rst;
        req.valid     = v;
        req.addr      = a;
        req.do_read   = rd;
        req.do_write  = wr;
        req.data      = d;
        req.user_tag  = tag;
        out_ready     = rdy;
        if (rst) begin
            mq.delete();
            m_ovf   = 0;
            m_halt  = 0;
            m_scr   = 0;
            e_valid = 0;
            e_addr  = 0;
            e_data  = 0;
            e_tag   = 0;
        end else begin
            isw   = v && (wr != 0);
            isr   = v && (wr == 0) && (rd != 0);
            inwin = (a[31:4] == BASE[31:4]);
            off   = a[3:2];
            e_valid = v;
            e_addr  = a;
            e_tag   = tag;
            e_data  = 0;
            if (isr && inwin && off == 2'd0) e_data = m_scr;
            if (isr && inwin && off == 2'd1) e_data = model_status();
            if (mq.size() > 0 && rdy) void'(mq.pop_front());
            if (isw && inwin) begin
                if (off == 2'd0) begin
                    for (int i = 0; i < 4; i++)
                        if (wr[i]) m_scr[8*i +: 8] = d[8*i +: 8];
                end
                if (off == 2'd2 && wr[0]) begin
                    if (mq.size() < DEPTH) mq.push_back(d[7:0]);
                    else m_ovf = 1;
                end
                if (off == 2'd3) m_halt = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        cycle(0, 0, 32'h0, 4'h0, 4'h0, 32'h0, 8'h0, rdy);
    endtask

    task automatic do_reset();
        cycle(1, 0, 32'h0, 4'h0, 4'h0, 32'h0, 8'h0, 0);
    endtask

    task automatic wr_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          input logic [7:0] tag, input bit rdy);
        cycle(0, 1, a, 4'h0, m, d, tag, rdy);
    endtask

    task automatic rd_req(input logic [31:0] a, input logic [7:0] tag, input bit rdy);
        cycle(0, 1, a, 4'hF, 4'h0, 32'h0, tag, rdy);
    endtask

    task automatic test_reset();
        do_reset();
        // A request presented during reset must not produce a response.
        cycle(1, 1, BASE + 32'h4, 4'hF, 4'h0, 32'h0, 8'h77, 1);
        checks += 6;
        if (rsp.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %0b expected 0", rsp.valid); end
        if (rsp.data !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsp_data: got %08h expected 0", rsp.data); end
        if (rsp.user_tag !== 8'h0) begin errors++; $display("[TB] FAIL reset_rsp_tag: got %02h expected 0", rsp.user_tag); end
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
        if (out_data !== 8'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %02h expected 0", out_data); end
        if (halt !== 1'b0) begin errors++; $display("[TB] FAIL reset_halt: got %0b expected 0", halt); end
        idle(0);
        checks++;
        if (rsp.valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_rsp_valid: got %0b expected 0", rsp.valid); end
    endtask

    task automatic test_hello();
        do_reset();
        wr_req(BASE + 32'h8, 32'h48, 4'b0001, 8'h11, 1);
        checks += 3;
        if (rsp.valid !== 1'b1 || rsp.user_tag !== 8'h11) begin errors++; $display("[TB] FAIL hello_rsp_h: got valid %0b tag %02h expected 1 11", rsp.valid, rsp.user_tag); end
        if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hello_valid_h: got %0b expected 1", out_valid); end
        if (out_data !== 8'h48) begin errors++; $display("[TB] FAIL hello_data_h: got %02h expected 48", out_data); end
        wr_req(BASE + 32'h8, 32'h69, 4'b0001, 8'h12, 1);
        checks += 2;
        if (rsp.valid !== 1'b1 || rsp.user_tag !== 8'h12) begin errors++; $display("[TB] FAIL hello_rsp_i: got valid %0b tag %02h expected 1 12", rsp.valid, rsp.user_tag); end
        if (out_valid !== 1'b1 || out_data !== 8'h69) begin errors++; $display("[TB] FAIL hello_data_i: got %0b/%02h expected 1/69", out_valid, out_data); end
        idle(1);
        checks++;
        if (out_valid !== 1'b0 || rsp.valid !== 1'b0) begin errors++; $display("[TB] FAIL hello_drained: got out_valid %0b rsp_valid %0b expected 0 0", out_valid, rsp.valid); end
    endtask

    task automatic test_overflow();
        logic [7:0] b[9];
        do_reset();
        for (int i = 0; i < 9; i++) begin
            b[i] = 8'($urandom);
            wr_req(BASE + 32'h8, {24'($urandom), b[i]}, {3'($urandom), 1'b1}, 8'(i), 0);
        end
        rd_req(BASE + 32'h4, 8'h3C, 0);
        checks++;
        if (rsp.data !== 32'h0000_0508) begin errors++; $display("[TB] FAIL overflow_status: got %08h expected 00000508", rsp.data); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== b[i]) begin errors++; $display("[TB] FAIL overflow_drain[%0d]: got %0b/%02h expected 1/%02h", i, out_valid, out_data, b[i]); end
            idle(1);
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL overflow_ninth_absent: got out_valid %0b expected 0", out_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] b[8];
        logic [7:0] exp;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            b[i] = 8'($urandom);
            wr_req(BASE + 32'h8, {24'h0, b[i]}, 4'b0001, 8'h0, 0);
        end
        wr_req(BASE + 32'h8, 32'h41, 4'b0001, 8'h0, 1);
        rd_req(BASE + 32'h4, 8'h0, 0);
        checks++;
        if (rsp.data !== 32'h0000_0108) begin errors++; $display("[TB] FAIL fullpp_status: got %08h expected 00000108", rsp.data); end
        for (int i = 0; i < 8; i++) begin
            exp = (i == 7) ? 8'h41 : b[i+1];
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp) begin errors++; $display("[TB] FAIL fullpp_drain[%0d]: got %0b/%02h expected 1/%02h", i, out_valid, out_data, exp); end
            idle(1);
        end
    endtask

    task automatic test_halt();
        do_reset();
        rd_req(BASE + 32'hC, 8'h01, 0);
        checks += 2;
        if (halt !== 1'b0) begin errors++; $display("[TB] FAIL halt_read_no_set: got %0b expected 0", halt); end
        if (rsp.data !== 32'h0) begin errors++; $display("[TB] FAIL halt_read_data: got %08h expected 0", rsp.data); end
        wr_req(BASE + 32'hC, 32'h1, 4'b0001, 8'h02, 0);
        checks++;
        if (halt !== 1'b1) begin errors++; $display("[TB] FAIL halt_set: got %0b expected 1", halt); end
        wr_req(BASE + 32'h8, 32'h7A, 4'b0001, 8'h03, 0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h7A) begin errors++; $display("[TB] FAIL halt_tx_accept: got %0b/%02h expected 1/7a", out_valid, out_data); end
        rd_req(BASE + 32'h4, 8'h04, 0);
        checks++;
        if (rsp.data !== 32'h0000_0801) begin errors++; $display("[TB] FAIL halt_status: got %08h expected 00000801", rsp.data); end
        for (int i = 0; i < 6; i++) begin
            wr_req(BASE + 32'h4 * 32'(i % 3), $urandom, 4'($urandom), 8'(i), 1);
            checks++;
            if (halt !== 1'b1) begin errors++; $display("[TB] FAIL halt_sticky[%0d]: got %0b expected 1", i, halt); end
        end
        do_reset();
        checks++;
        if (halt !== 1'b0) begin errors++; $display("[TB] FAIL halt_cleared: got %0b expected 0", halt); end
    endtask

    task automatic test_scratch();
        do_reset();
        wr_req(BASE, 32'hDEAD_BEEF, 4'b0011, 8'h5A, 0);
        checks++;
        if (rsp.valid !== 1'b1 || rsp.user_tag !== 8'h5A) begin errors++; $display("[TB] FAIL scratch_wr_rsp: got %0b/%02h expected 1/5a", rsp.valid, rsp.user_tag); end
        rd_req(BASE, 8'hA5, 0);
        checks += 2;
        if (rsp.data !== 32'h0000_BEEF) begin errors++; $display("[TB] FAIL scratch_rd_data: got %08h expected 0000beef", rsp.data); end
        if (rsp.user_tag !== 8'hA5 || rsp.addr !== BASE) begin errors++; $display("[TB] FAIL scratch_rd_tag: got %02h/%08h expected a5/%08h", rsp.user_tag, rsp.addr, BASE); end
        rd_req(BASE + 32'h8, 8'hA6, 0);
        checks++;
        if (rsp.valid !== 1'b1 || rsp.data !== 32'h0) begin errors++; $display("[TB] FAIL txdata_read_zero: got %0b/%08h expected 1/0", rsp.valid, rsp.data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) wr_req(BASE + 32'h8, 32'h30 + 32'(i), 4'b0001, 8'h0, 0);
        cycle(1, 1, BASE + 32'h4, 4'hF, 4'h0, 32'h0, 8'h33, 0);
        checks += 2;
        if (rsp.valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_no_rsp: got %0b expected 0", rsp.valid); end
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_out_valid: got %0b expected 0", out_valid); end
        rd_req(BASE + 32'h4, 8'h34, 0);
        checks++;
        if (rsp.valid !== 1'b1 || rsp.data !== 32'h0000_0200) begin errors++; $display("[TB] FAIL midreset_status: got %0b/%08h expected 1/00000200", rsp.valid, rsp.data); end
    endtask

    task automatic test_back_to_back_random();
        int          s;
        logic [31:0] a;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            s = int'($urandom_range(0, 15));
            if (s <= 2)       a = BASE;
            else if (s <= 5)  a = BASE + 32'h4;
            else if (s <= 11) a = BASE + 32'h8;
            else if (s == 12) a = BASE + 32'hC;
            else if (s == 13) a = BASE + 32'h10;
            else if (s == 14) a = $urandom;
            else              a = BASE + 32'h4 + 32'($urandom_range(0, 3));
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), a,
                  4'($urandom), ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
                  $urandom, 8'($urandom), ($urandom_range(0, 2) == 0));
            checks++;
            if (rsp.valid !== e_valid) begin errors++; $display("[TB] FAIL rnd_rsp_valid[%0d]: got %0b expected %0b", n, rsp.valid, e_valid); end
            if (e_valid) begin
                checks++;
                if (rsp.data !== e_data || rsp.addr !== e_addr || rsp.user_tag !== e_tag) begin
                    errors++;
                    $display("[TB] FAIL rnd_rsp[%0d]: got %08h/%08h/%02h expected %08h/%08h/%02h", n, rsp.data, rsp.addr, rsp.user_tag, e_data, e_addr, e_tag);
                end
            end
            checks++;
            if (out_valid !== (mq.size() > 0) || out_data !== ((mq.size() > 0) ? mq[0] : 8'h00) || halt !== m_halt) begin
                errors++;
                $display("[TB] FAIL rnd_out[%0d]: got %0b/%02h/%0b expected %0b/%02h/%0b", n, out_valid, out_data, halt,
                         (mq.size() > 0), ((mq.size() > 0) ? mq[0] : 8'h00), m_halt);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        test_reset();
        test_hello();
        test_overflow();
        test_full_push_pop();
        test_halt();
        test_scratch();
        test_reset_mid();
        test_back_to_back_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
